// File: rtl/tetris_game_sequencer.sv
// tetris_game_sequencer: falling-piece flow controller (gravity, key moves, checker/lock/clear handshakes).
// Optional HARD_DROP_EN: key 8'h29 enables back-to-back down checks until the piece locks.
//  state     | meaning
//  FALL_WAIT | idle, waiting for a gravity tick or key move
//  CHECK     | collision query for a down or lateral candidate
//  LOCK      | grid write of the current piece
//  CLEAR     | full-row clear
//  SPAWN     | new piece type and position
//  SPAWN_CHK | collision query at spawn position
//  GAME_OVER | terminal, left only by reset
module tetris_game_sequencer #(
  parameter int GRAV_DIV = 10000000,
  parameter int CELL     = 16,
  parameter int SPAWN_X  = 320,
  parameter int SPAWN_Y  = 0,
  parameter int NTYPES   = 5
) (
  input  logic        iVGA_CLK,
  input  logic        iRST_n,
  input  logic [7:0]  key_in,
  input  logic        key_en,
  input  logic [12:0] rnd,
  output logic        chk_req,
  output logic [9:0]  chk_x,
  output logic [9:0]  chk_y,
  input  logic        chk_ack,
  input  logic        chk_hit,
  output logic        lock_req,
  input  logic        lock_done,
  output logic        clr_req,
  input  logic        clr_done,
  output logic [9:0]  ref_x,
  output logic [9:0]  ref_y,
  output logic [2:0]  block_type,
  output logic        game_over,
  output logic [2:0]  state_dbg
);

  localparam int CNT_W = (GRAV_DIV > 1) ? $clog2(GRAV_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GRAV_DIV - 1);
  localparam logic [9:0] CELL_V    = 10'(CELL);
  localparam logic [9:0] SPAWN_X_V = 10'(SPAWN_X);
  localparam logic [9:0] SPAWN_Y_V = 10'(SPAWN_Y);
  localparam logic [7:0] KEY_LEFT  = 8'h6b;
  localparam logic [7:0] KEY_RIGHT = 8'h74;

  typedef enum logic [2:0] {
    S_FALL_WAIT = 3'd0,
    S_CHECK     = 3'd1,
    S_LOCK      = 3'd2,
    S_CLEAR     = 3'd3,
    S_SPAWN     = 3'd4,
    S_SPAWN_CHK = 3'd5,
    S_GAME_OVER = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] grav_cnt_q, grav_cnt_d;
  logic             tick_pend_q, tick_pend_d;
  logic             key_pend_q, key_pend_d;
  logic             key_right_q, key_right_d;
  logic             cand_down_q, cand_down_d;
  logic [9:0]       cand_x_q, cand_x_d;
  logic [9:0]       cand_y_q, cand_y_d;
  logic [9:0]       ref_x_q, ref_x_d;
  logic [9:0]       ref_y_q, ref_y_d;
  logic [2:0]       block_type_q, block_type_d;
  logic             chk_req_q, chk_req_d;
  logic             lock_req_q, lock_req_d;
  logic             clr_req_q, clr_req_d;
  logic             game_over_q, game_over_d;
  logic             drop_active;
  logic             tick, key_move, chk_ok, lock_ok, clr_ok, alive;

`ifdef HARD_DROP_EN
  localparam logic [7:0] KEY_DROP = 8'h29;
  logic drop_mode_q, drop_mode_d;
  assign drop_active = drop_mode_q;
`else
  assign drop_active = 1'b0;
`endif

  assign alive    = (state_q != S_GAME_OVER);
  assign tick     = alive && (grav_cnt_q == CNT_LAST);
  assign key_move = alive && key_en && ((key_in == KEY_LEFT) || (key_in == KEY_RIGHT));
  // Responses are only honoured while the matching request is actually raised.
  assign chk_ok   = chk_ack && chk_req_q;
  assign lock_ok  = lock_done && lock_req_q;
  assign clr_ok   = clr_done && clr_req_q;

  always_comb begin
    state_d      = state_q;
    grav_cnt_d   = grav_cnt_q;
    tick_pend_d  = tick_pend_q;
    key_pend_d   = key_pend_q;
    key_right_d  = key_right_q;
    cand_down_d  = cand_down_q;
    cand_x_d     = cand_x_q;
    cand_y_d     = cand_y_q;
    ref_x_d      = ref_x_q;
    ref_y_d      = ref_y_q;
    block_type_d = block_type_q;
`ifdef HARD_DROP_EN
    drop_mode_d  = drop_mode_q;
`endif

    if (alive) grav_cnt_d = tick ? '0 : grav_cnt_q + CNT_W'(1);

    case (state_q)
      S_FALL_WAIT: begin
        if (tick_pend_q || drop_active) begin
          state_d     = S_CHECK;
          cand_down_d = 1'b1;
          cand_x_d    = ref_x_q;
          cand_y_d    = ref_y_q + CELL_V;
          tick_pend_d = 1'b0;
        end else if (key_pend_q) begin
          state_d     = S_CHECK;
          cand_down_d = 1'b0;
          cand_x_d    = key_right_q ? (ref_x_q + CELL_V) : (ref_x_q - CELL_V);
          cand_y_d    = ref_y_q;
          key_pend_d  = 1'b0;
        end
      end
      S_CHECK: begin
        if (chk_ok) begin
          if (!chk_hit) begin
            ref_x_d = cand_x_q;
            ref_y_d = cand_y_q;
            state_d = S_FALL_WAIT;
          end else if (cand_down_q) begin
            state_d = S_LOCK;
`ifdef HARD_DROP_EN
            drop_mode_d = 1'b0;
`endif
          end else begin
            state_d = S_FALL_WAIT;
          end
        end
      end
      S_LOCK:  if (lock_ok) state_d = S_CLEAR;
      S_CLEAR: if (clr_ok) state_d = S_SPAWN;
      S_SPAWN: begin
        block_type_d = 3'(rnd % 13'(NTYPES));
        ref_x_d      = SPAWN_X_V;
        ref_y_d      = SPAWN_Y_V;
        cand_x_d     = SPAWN_X_V;
        cand_y_d     = SPAWN_Y_V;
        cand_down_d  = 1'b0;
        state_d      = S_SPAWN_CHK;
      end
      S_SPAWN_CHK: if (chk_ok) state_d = chk_hit ? S_GAME_OVER : S_FALL_WAIT;
      S_GAME_OVER: state_d = S_GAME_OVER;
      default:     state_d = S_SPAWN_CHK;
    endcase

    // New events win over a same-cycle consume; SPAWN flushes everything.
    if (tick) tick_pend_d = 1'b1;
    if (key_move) begin
      key_pend_d  = 1'b1;
      key_right_d = (key_in == KEY_RIGHT);
    end
`ifdef HARD_DROP_EN
    if (alive && key_en && (key_in == KEY_DROP)) drop_mode_d = 1'b1;
    if (state_q == S_SPAWN) drop_mode_d = 1'b0;
`endif
    if (state_q == S_SPAWN) begin
      tick_pend_d = 1'b0;
      key_pend_d  = 1'b0;
    end

    chk_req_d   = (state_d == S_CHECK) || (state_d == S_SPAWN_CHK);
    lock_req_d  = (state_d == S_LOCK);
    clr_req_d   = (state_d == S_CLEAR);
    game_over_d = game_over_q || (state_d == S_GAME_OVER);
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q      <= S_SPAWN_CHK;
      grav_cnt_q   <= '0;
      tick_pend_q  <= 1'b0;
      key_pend_q   <= 1'b0;
      key_right_q  <= 1'b0;
      cand_down_q  <= 1'b0;
      cand_x_q     <= SPAWN_X_V;
      cand_y_q     <= SPAWN_Y_V;
      ref_x_q      <= SPAWN_X_V;
      ref_y_q      <= SPAWN_Y_V;
      block_type_q <= 3'd4;
      chk_req_q    <= 1'b0;
      lock_req_q   <= 1'b0;
      clr_req_q    <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      grav_cnt_q   <= grav_cnt_d;
      tick_pend_q  <= tick_pend_d;
      key_pend_q   <= key_pend_d;
      key_right_q  <= key_right_d;
      cand_down_q  <= cand_down_d;
      cand_x_q     <= cand_x_d;
      cand_y_q     <= cand_y_d;
      ref_x_q      <= ref_x_d;
      ref_y_q      <= ref_y_d;
      block_type_q <= block_type_d;
      chk_req_q    <= chk_req_d;
      lock_req_q   <= lock_req_d;
      clr_req_q    <= clr_req_d;
      game_over_q  <= game_over_d;
    end
  end

`ifdef HARD_DROP_EN
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) drop_mode_q <= 1'b0;
    else         drop_mode_q <= drop_mode_d;
  end
`endif

  assign chk_req    = chk_req_q;
  assign chk_x      = cand_x_q;
  assign chk_y      = cand_y_q;
  assign lock_req   = lock_req_q;
  assign clr_req    = clr_req_q;
  assign ref_x      = ref_x_q;
  assign ref_y      = ref_y_q;
  assign block_type = block_type_q;
  assign game_over  = game_over_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_tetris_game_sequencer.sv
// Bench for tetris_game_sequencer with a fast gravity tick; expected positions come from a
// tick-phase timebase and move arithmetic kept here.
module tb_tetris_game_sequencer;
  localparam int GD   = 8;
  localparam int CELL = 16;
  localparam logic [2:0] ST_FALL_WAIT = 3'd0;
  localparam logic [2:0] ST_SPAWN_CHK = 3'd5;
  localparam logic [2:0] ST_GAME_OVER = 3'd6;

  logic        iVGA_CLK = 1'b0;
  logic        iRST_n = 1'b0;
  logic [7:0]  key_in = 8'h00;
  logic        key_en = 1'b0;
  logic [12:0] rnd = 13'd0;
  logic        chk_req, chk_ack = 1'b0, chk_hit = 1'b0;
  logic [9:0]  chk_x, chk_y, ref_x, ref_y;
  logic        lock_req, lock_done = 1'b0, clr_req, clr_done = 1'b0;
  logic [2:0]  block_type, state_dbg;
  logic        game_over;

  int checks = 0;
  int failures = 0;
  int cyc;
  logic [9:0] exp_x, exp_y;
  logic [2:0] exp_type;

  tetris_game_sequencer #(.GRAV_DIV(GD), .CELL(CELL), .SPAWN_X(320), .SPAWN_Y(0), .NTYPES(5)) dut (
    .iVGA_CLK(iVGA_CLK), .iRST_n(iRST_n), .key_in(key_in), .key_en(key_en), .rnd(rnd),
    .chk_req(chk_req), .chk_x(chk_x), .chk_y(chk_y), .chk_ack(chk_ack), .chk_hit(chk_hit),
    .lock_req(lock_req), .lock_done(lock_done), .clr_req(clr_req), .clr_done(clr_done),
    .ref_x(ref_x), .ref_y(ref_y), .block_type(block_type), .game_over(game_over),
    .state_dbg(state_dbg)
  );

  always #5 iVGA_CLK = ~iVGA_CLK;

  // Clock edges since reset release; gravity ticks land on edges that are multiples of GD.
  always @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset();
    iRST_n = 1'b0; key_en = 1'b0; chk_ack = 1'b0; chk_hit = 1'b0;
    lock_done = 1'b0; clr_done = 1'b0;
    repeat (3) @(negedge iVGA_CLK);
    iRST_n = 1'b1;
    exp_x = 10'd320; exp_y = 10'd0; exp_type = 3'd4;
  endtask

  task automatic wait_out(input int which, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if ((which == 0 && chk_req) || (which == 1 && lock_req) || (which == 2 && clr_req)) begin
        ok = 1'b1;
        break;
      end
      @(negedge iVGA_CLK);
    end
  endtask

  task automatic send_ack(input bit hit, input int lat);
    repeat (lat) @(negedge iVGA_CLK);
    chk_ack = 1'b1; chk_hit = hit;
    @(negedge iVGA_CLK);
    chk_ack = 1'b0; chk_hit = 1'b0;
  endtask

  task automatic pulse_key(input logic [7:0] code);
    key_in = code; key_en = 1'b1;
    @(negedge iVGA_CLK);
    key_en = 1'b0;
  endtask

  task automatic test_reset();
    bit ok;
    do_reset();
    checks++; if ({chk_req, lock_req, clr_req} !== 3'b000) begin failures++; $display("FAIL reset_req: got %b expected 000", {chk_req, lock_req, clr_req}); end
    checks++; if (ref_x !== 10'd320 || ref_y !== 10'd0) begin failures++; $display("FAIL reset_ref: got (%0d,%0d) expected (320,0)", ref_x, ref_y); end
    checks++; if (block_type !== 3'd4 || game_over !== 1'b0) begin failures++; $display("FAIL reset_type_go: got %0d/%0d expected 4/0", block_type, game_over); end
    checks++; if (state_dbg !== ST_SPAWN_CHK) begin failures++; $display("FAIL reset_state: got %0d expected %0d", state_dbg, ST_SPAWN_CHK); end
    wait_out(0, ok);
    checks++; if (!ok) begin failures++; $display("FAIL spawn_req_timeout: got none expected chk_req"); end
    checks++; if (chk_x !== 10'd320 || chk_y !== 10'd0) begin failures++; $display("FAIL spawn_cand: got (%0d,%0d) expected (320,0)", chk_x, chk_y); end
    send_ack(1'b0, $urandom_range(3));
    checks++; if (state_dbg !== ST_FALL_WAIT) begin failures++; $display("FAIL spawn_to_fall: got %0d expected %0d", state_dbg, ST_FALL_WAIT); end
    checks++; if (ref_x !== exp_x || ref_y !== exp_y || block_type !== exp_type) begin failures++; $display("FAIL spawn_ref: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)", ref_x, ref_y, block_type, exp_x, exp_y, exp_type); end
  endtask

  task automatic test_gravity();
    bit ok;
    int prev = -1;
    for (int i = 0; i < 3; i++) begin
      wait_out(0, ok);
      checks++; if (!ok) begin failures++; $display("FAIL grav_timeout: got none expected chk_req step %0d", i); end
      checks++; if (chk_x !== exp_x || chk_y !== exp_y + 10'(CELL)) begin failures++; $display("FAIL grav_cand: got (%0d,%0d) expected (%0d,%0d)", chk_x, chk_y, exp_x, exp_y + 10'(CELL)); end
      checks++; if (cyc % GD != 1) begin failures++; $display("FAIL grav_phase: got cycle %0d expected tick edge + 1", cyc); end
      if (i > 0) begin
        checks++; if (cyc - prev != GD) begin failures++; $display("FAIL grav_period: got %0d expected %0d", cyc - prev, GD); end
      end
      prev = cyc;
      send_ack(1'b0, $urandom_range(3));
      exp_y = exp_y + 10'(CELL);
      checks++; if (ref_y !== exp_y || ref_x !== exp_x) begin failures++; $display("FAIL grav_commit: got (%0d,%0d) expected (%0d,%0d)", ref_x, ref_y, exp_x, exp_y); end
    end
  endtask

  task automatic test_tick_key();
    bit ok;
    // Responses with no request outstanding must be ignored.
    chk_ack = 1'b1; chk_hit = 1'b1; lock_done = 1'b1; clr_done = 1'b1;
    @(negedge iVGA_CLK);
    chk_ack = 1'b0; chk_hit = 1'b0; lock_done = 1'b0; clr_done = 1'b0;
    checks++; if ({chk_req, lock_req, clr_req} !== 3'b000 || state_dbg !== ST_FALL_WAIT) begin failures++; $display("FAIL stray_ack: got req %b state %0d expected 000/%0d", {chk_req, lock_req, clr_req}, state_dbg, ST_FALL_WAIT); end
    for (int i = 0; i < 16 && (cyc % GD != GD - 1); i++) @(negedge iVGA_CLK);
    pulse_key(8'h6b);
    wait_out(0, ok);
    checks++; if (!ok || chk_x !== exp_x || chk_y !== exp_y + 10'(CELL)) begin failures++; $display("FAIL tick_first: got ok=%0d (%0d,%0d) expected (%0d,%0d)", ok, chk_x, chk_y, exp_x, exp_y + 10'(CELL)); end
    send_ack(1'b0, 0);
    exp_y = exp_y + 10'(CELL);
    wait_out(0, ok);
    checks++; if (!ok || chk_x !== exp_x - 10'(CELL) || chk_y !== exp_y) begin failures++; $display("FAIL key_second: got ok=%0d (%0d,%0d) expected (%0d,%0d)", ok, chk_x, chk_y, exp_x - 10'(CELL), exp_y); end
    send_ack(1'b0, 0);
    exp_x = exp_x - 10'(CELL);
    checks++; if (ref_x !== 10'd304 || ref_y !== exp_y) begin failures++; $display("FAIL key_commit: got (%0d,%0d) expected (304,%0d)", ref_x, ref_y, exp_y); end
  endtask

  task automatic test_random_moves();
    bit ok, hit;
    int kind;
    logic [7:0] code;
    logic [9:0] cx;
    for (int it = 0; it < 12; it++) begin
      wait_out(0, ok);
      checks++; if (!ok || chk_x !== exp_x || chk_y !== exp_y + 10'(CELL) || cyc % GD != 1) begin failures++; $display("FAIL rnd_down: got ok=%0d (%0d,%0d) cyc %0d expected (%0d,%0d)", ok, chk_x, chk_y, cyc, exp_x, exp_y + 10'(CELL)); end
      send_ack(1'b0, $urandom_range(1));
      exp_y = exp_y + 10'(CELL);
      kind = $urandom_range(2);
      if (kind == 0) code = 8'h6b;
      else if (kind == 1) code = 8'h74;
      else begin
        code = 8'($urandom_range(255));
        while (code == 8'h6b || code == 8'h74) code = 8'($urandom_range(255));
      end
      pulse_key(code);
      if (kind < 2) begin
        cx = (kind == 1) ? exp_x + 10'(CELL) : exp_x - 10'(CELL);
        wait_out(0, ok);
        checks++; if (!ok || chk_x !== cx || chk_y !== exp_y) begin failures++; $display("FAIL rnd_lateral: got ok=%0d (%0d,%0d) expected (%0d,%0d)", ok, chk_x, chk_y, cx, exp_y); end
        hit = 1'($urandom_range(1));
        send_ack(hit, $urandom_range(1));
        if (!hit) exp_x = cx;
        checks++; if (ref_x !== exp_x || ref_y !== exp_y) begin failures++; $display("FAIL rnd_commit: got (%0d,%0d) expected (%0d,%0d) hit=%0d", ref_x, ref_y, exp_x, exp_y, hit); end
      end
    end
  endtask

  task automatic test_lock_clear_spawn();
    bit ok;
    for (int n = 0; n < 2; n++) begin
      rnd = (n == 0) ? 13'd7 : 13'($urandom);
      exp_type = (n == 0) ? 3'd2 : 3'(rnd % 13'd5);
      wait_out(0, ok);
      checks++; if (!ok || chk_x !== exp_x || chk_y !== exp_y + 10'(CELL)) begin failures++; $display("FAIL lock_down: got ok=%0d (%0d,%0d) expected (%0d,%0d)", ok, chk_x, chk_y, exp_x, exp_y + 10'(CELL)); end
      send_ack(1'b1, $urandom_range(2));
      wait_out(1, ok);
      checks++; if (!ok || chk_req !== 1'b0 || ref_y !== exp_y) begin failures++; $display("FAIL lock_req: got ok=%0d chk_req=%0d ref_y=%0d expected 1/0/%0d", ok, chk_req, ref_y, exp_y); end
      repeat ($urandom_range(4)) @(negedge iVGA_CLK);
      checks++; if (lock_req !== 1'b1) begin failures++; $display("FAIL lock_hold: got %0d expected 1", lock_req); end
      lock_done = 1'b1; @(negedge iVGA_CLK); lock_done = 1'b0;
      checks++; if (lock_req !== 1'b0) begin failures++; $display("FAIL lock_drop: got %0d expected 0", lock_req); end
      wait_out(2, ok);
      repeat ($urandom_range(4)) @(negedge iVGA_CLK);
      checks++; if (!ok || clr_req !== 1'b1) begin failures++; $display("FAIL clr_req: got ok=%0d clr_req=%0d expected 1/1", ok, clr_req); end
      clr_done = 1'b1; @(negedge iVGA_CLK); clr_done = 1'b0;
      checks++; if (clr_req !== 1'b0) begin failures++; $display("FAIL clr_drop: got %0d expected 0", clr_req); end
      wait_out(0, ok);
      exp_x = 10'd320; exp_y = 10'd0;
      checks++; if (!ok || chk_x !== exp_x || chk_y !== exp_y || ref_x !== exp_x || ref_y !== exp_y) begin failures++; $display("FAIL respawn_pos: got ok=%0d chk (%0d,%0d) ref (%0d,%0d) expected (320,0)", ok, chk_x, chk_y, ref_x, ref_y); end
      checks++; if (block_type !== exp_type) begin failures++; $display("FAIL respawn_type: got %0d expected %0d rnd=%0d", block_type, exp_type, rnd); end
      send_ack(1'b0, $urandom_range(3));
      checks++; if (state_dbg !== ST_FALL_WAIT || game_over !== 1'b0) begin failures++; $display("FAIL respawn_fall: got state %0d go %0d expected %0d/0", state_dbg, game_over, ST_FALL_WAIT); end
    end
  endtask

  task automatic test_reset_mid_handshake();
    bit ok;
    wait_out(0, ok);
    send_ack(1'b0, 0);
    exp_y = exp_y + 10'(CELL);
    checks++; if (!ok || ref_y !== exp_y) begin failures++; $display("FAIL pre_reset_step: got ok=%0d ref_y=%0d expected %0d", ok, ref_y, exp_y); end
    wait_out(0, ok);
    iRST_n = 1'b0;
    #1;
    checks++; if (!ok || chk_req !== 1'b0) begin failures++; $display("FAIL reset_drop_req: got ok=%0d chk_req=%0d expected 0", ok, chk_req); end
    checks++; if (ref_x !== 10'd320 || ref_y !== 10'd0 || block_type !== 3'd4) begin failures++; $display("FAIL reset_mid_ref: got (%0d,%0d,%0d) expected (320,0,4)", ref_x, ref_y, block_type); end
    do_reset();
  endtask

  task automatic test_game_over();
    bit ok;
    int seen = 0;
    wait_out(0, ok);
    checks++; if (!ok || chk_x !== 10'd320 || chk_y !== 10'd0) begin failures++; $display("FAIL go_spawn: got ok=%0d (%0d,%0d) expected (320,0)", ok, chk_x, chk_y); end
    send_ack(1'b1, $urandom_range(3));
    checks++; if (game_over !== 1'b1 || state_dbg !== ST_GAME_OVER) begin failures++; $display("FAIL go_set: got %0d state %0d expected 1/%0d", game_over, state_dbg, ST_GAME_OVER); end
    for (int i = 0; i < 40; i++) begin
      key_in = ($urandom_range(1) != 0) ? 8'h6b : 8'h74;
      key_en = 1'($urandom_range(1));
      chk_ack = 1'($urandom_range(1));
      @(negedge iVGA_CLK);
      if (chk_req || lock_req || clr_req) seen++;
    end
    key_en = 1'b0; chk_ack = 1'b0;
    checks++; if (seen != 0) begin failures++; $display("FAIL go_no_req: got %0d req cycles expected 0", seen); end
    checks++; if (game_over !== 1'b1 || ref_x !== 10'd320 || ref_y !== 10'd0) begin failures++; $display("FAIL go_sticky: got go=%0d (%0d,%0d) expected 1 (320,0)", game_over, ref_x, ref_y); end
  endtask

  initial begin
    test_reset();
    test_gravity();
    test_tick_key();
    test_random_moves();
    test_lock_clear_spawn();
    test_reset_mid_handshake();
    test_game_over();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
